// File: rtl/shared_mem_responder.sv
// Shared single-port word memory serving NCORE cores through a round-robin
// IDLE/ACCESS/RESP sequencer. Optional macro SMEM_ERR_CHECK_EN adds the err port.
module shared_mem_responder #(
    parameter int DEPTH = 32,
    parameter int NCORE = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NCORE-1:0]      req,
    input  logic [NCORE-1:0]      rd,
    input  logic [NCORE-1:0]      wr,
    input  logic [32*NCORE-1:0]   addr,
    input  logic [32*NCORE-1:0]   todata,
    output logic [NCORE-1:0]      ack,
    output logic [31:0]           fromdata,
    output logic                  busy
`ifdef SMEM_ERR_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDW = (NCORE > 1) ? $clog2(NCORE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDW-1:0]     rr_ptr_r;
    logic [IDW-1:0]     id_r;
    logic [IDW-1:0]     grant_id_s;
    logic               grant_valid_s;
    logic               rd_r;
    logic               wr_r;
    logic [AW-1:0]      addr_r;
    logic [31:0]        data_r;
    logic [31:0]        mem [DEPTH];
    logic               do_write_s;
    logic               do_read_s;
    logic [31:0]        result_r;
    logic [NCORE-1:0]   ack_next_s;
    logic [31:0]        fromdata_next_s;
    logic [NCORE-1:0]   ack_r;
    logic [31:0]        fromdata_r;
    logic               addr_unused_s;
`ifdef SMEM_ERR_CHECK_EN
    logic               illegal_s;
    logic               illegal_r;
    logic               err_next_s;
    logic               err_r;
`endif

    // Address bits above the memory index are deliberately ignored.
    assign addr_unused_s = ^addr;

    // Round-robin search upward from rr_ptr, wrapping at NCORE-1.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (!grant_valid_s && req[(int'(rr_ptr_r) + i) % NCORE]) begin
                grant_valid_s = 1'b1;
                grant_id_s    = IDW'((int'(rr_ptr_r) + i) % NCORE);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE:   state_next_s = grant_valid_s ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Grant-time capture of the winning core's request and pointer advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= '0;
            id_r     <= '0;
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            addr_r   <= '0;
            data_r   <= 32'd0;
        end else if (state_r == ST_IDLE && grant_valid_s) begin
            id_r     <= grant_id_s;
            rd_r     <= rd[grant_id_s];
            wr_r     <= wr[grant_id_s];
            addr_r   <= addr[int'(grant_id_s) * 32 +: AW];
            data_r   <= todata[int'(grant_id_s) * 32 +: 32];
            rr_ptr_r <= (grant_id_s == IDW'(NCORE - 1)) ? '0 : grant_id_s + 1'b1;
        end
    end

    // Operation decode; a simultaneous rd+wr is either flagged or write-wins.
    always_comb begin
`ifdef SMEM_ERR_CHECK_EN
        illegal_s  = rd_r & wr_r;
        do_write_s = wr_r & ~rd_r;
`else
        do_write_s = wr_r;
`endif
        do_read_s  = rd_r & ~wr_r;
    end

    // Memory array is intentionally not reset; aborted writes never reach it.
    always_ff @(posedge clk) begin
        if (state_r == ST_ACCESS && do_write_s) begin
            mem[addr_r] <= data_r;
        end
    end

    // Access-phase result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_r  <= 32'd0;
`ifdef SMEM_ERR_CHECK_EN
            illegal_r <= 1'b0;
`endif
        end else if (state_r == ST_ACCESS) begin
            result_r  <= do_write_s ? data_r : (do_read_s ? mem[addr_r] : 32'd0);
`ifdef SMEM_ERR_CHECK_EN
            illegal_r <= illegal_s;
`endif
        end
    end

    // Response outputs are only non-zero for the RESP phase.
    always_comb begin
        ack_next_s      = '0;
        fromdata_next_s = 32'd0;
`ifdef SMEM_ERR_CHECK_EN
        err_next_s      = 1'b0;
`endif
        if (state_r == ST_RESP) begin
            ack_next_s[id_r] = 1'b1;
            fromdata_next_s  = result_r;
`ifdef SMEM_ERR_CHECK_EN
            err_next_s       = illegal_r;
`endif
        end else begin
            ack_next_s      = '0;
            fromdata_next_s = 32'd0;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_r      <= '0;
            fromdata_r <= 32'd0;
`ifdef SMEM_ERR_CHECK_EN
            err_r      <= 1'b0;
`endif
        end else begin
            ack_r      <= ack_next_s;
            fromdata_r <= fromdata_next_s;
`ifdef SMEM_ERR_CHECK_EN
            err_r      <= err_next_s;
`endif
        end
    end

    assign ack      = ack_r;
    assign fromdata = fromdata_r;
    assign busy     = (state_r != ST_IDLE);
`ifdef SMEM_ERR_CHECK_EN
    assign err      = err_r;
`endif

endmodule

// File: tb/tb_shared_mem_responder.sv
// Randomized self-checking bench for shared_mem_responder against a
// transaction-level memory/arbitration model.
module tb_shared_mem_responder;

    localparam int DEPTH = 32;
    localparam int NCORE = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = 4'd0;
    logic [3:0]   rd = 4'd0;
    logic [3:0]   wr = 4'd0;
    logic [127:0] addr = 128'd0;
    logic [127:0] todata = 128'd0;
    logic [3:0]   ack;
    logic [31:0]  fromdata;
    logic         busy;
`ifdef SMEM_ERR_CHECK_EN
    logic         err;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  model_mem [DEPTH];
    int           rr_model = 0;

    shared_mem_responder #(.DEPTH(DEPTH), .NCORE(NCORE)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .todata   (todata),
        .ack      (ack),
        .fromdata (fromdata),
        .busy     (busy)
`ifdef SMEM_ERR_CHECK_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_err(input string tag, input logic e);
`ifdef SMEM_ERR_CHECK_EN
        check(tag, {31'd0, err}, {31'd0, e});
`else
        if (e) $display("note: %s expects err but port is absent", tag);
`endif
    endtask

    // Transaction-level effect of one request on the model memory.
    function automatic logic [31:0] model_op(input logic r, input logic w,
                                             input logic [31:0] a, input logic [31:0] d,
                                             output logic e);
        int idx;
        idx = int'(a % DEPTH);
        e = 1'b0;
`ifdef SMEM_ERR_CHECK_EN
        if (r && w) begin
            e = 1'b1;
            return 32'd0;
        end
`endif
        if (w) begin
            model_mem[idx] = d;
            return d;
        end
        if (r) return model_mem[idx];
        return 32'd0;
    endfunction

    task automatic set_core(input int c, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        req[c] = 1'b1;
        rd[c] = r;
        wr[c] = w;
        addr[c*32 +: 32] = a;
        todata[c*32 +: 32] = d;
    endtask

    function automatic logic [31:0] onehot(input int c);
        logic [31:0] v;
        v = 32'd0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Single-core transaction with latency, phase and result checks.
    task automatic single(input int c, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        logic [31:0] expd;
        logic        e;
        @(negedge clk);
        set_core(c, r, w, a, d);
        expd = model_op(r, w, a, d, e);
        rr_model = (c + 1) % NCORE;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check({tag, "_early_ack"}, 32'(ack), 32'd0);
            check({tag, "_early_data"}, fromdata, 32'd0);
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check({tag, "_ack"}, 32'(ack), onehot(c));
        check({tag, "_data"}, fromdata, expd);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check_err({tag, "_err"}, e);
        req[c] = 1'b0;
        @(negedge clk);
        check({tag, "_ack_clr"}, 32'(ack), 32'd0);
        check({tag, "_data_clr"}, fromdata, 32'd0);
    endtask

    initial begin
        logic [31:0] a4 [NCORE];
        logic [31:0] d4 [NCORE];
        logic        r4 [NCORE];
        logic        w4 [NCORE];
        logic [3:0]  pending;
        logic [31:0] expd;
        logic        e;
        int          w;
        int          a;

        // Reset state
        #12;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", fromdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_err("rst_err", 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill memory so the model is fully known
        for (int i = 0; i < DEPTH; i++) begin
            single(i % NCORE, 1'b0, 1'b1, 32'(i), $urandom, "init");
        end

        // Write then read
        single(0, 1'b0, 1'b1, 32'd3, 32'h145, "wr3");
        single(0, 1'b1, 1'b0, 32'd3, 32'd0, "rd3");

        // Address wrap
        single(1, 1'b0, 1'b1, 32'd33, 32'h13BA, "wr33");
        single(3, 1'b1, 1'b0, 32'd1, 32'd0, "rd1");

        // Idle request
        a = int'($urandom_range(0, DEPTH - 1));
        single(1, 1'b0, 1'b0, 32'(a), $urandom, "noop");
        single(1, 1'b1, 1'b0, 32'(a), 32'd0, "noop_rb");

        // Illegal rd+wr
        single(2, 1'b1, 1'b1, 32'd7, 32'h898, "illegal");
        single(2, 1'b1, 1'b0, 32'd7, 32'd0, "illegal_rb");

        // Random single-core traffic
        for (int i = 0; i < 20; i++) begin
            single(int'($urandom_range(0, NCORE - 1)), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 255), $urandom, "rand");
        end

        // Reset during ACCESS of a write
        @(negedge clk);
        set_core(0, 1'b0, 1'b1, 32'd5, 32'hFFFF);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        req = 4'd0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rr_model = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_noack", 32'(ack), 32'd0);
        end
        single(3, 1'b1, 1'b0, 32'd5, 32'd0, "abort_rb");

        // Fairness: all cores hold read requests from reset
        @(negedge clk);
        reset_n = 1'b0;
        for (int c = 0; c < NCORE; c++) begin
            a4[c] = $urandom_range(0, 255);
            set_core(c, 1'b1, 1'b0, a4[c], 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rr_model = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k % 3 == 0) begin
                w = rr_model;
                rr_model = (w + 1) % NCORE;
                check("fair_ack", 32'(ack), onehot(w));
                check("fair_data", fromdata, model_mem[a4[w] % DEPTH]);
            end else begin
                check("fair_gap", 32'(ack), 32'd0);
            end
        end
        req = 4'd0;
        @(negedge clk);

        // Random contention rounds
        for (int round = 0; round < 8; round++) begin
            @(negedge clk);
            pending = 4'($urandom_range(1, 15));
            for (int c = 0; c < NCORE; c++) begin
                r4[c] = 1'($urandom);
                w4[c] = 1'($urandom);
                a4[c] = $urandom_range(0, 255);
                d4[c] = $urandom;
                if (pending[c]) set_core(c, r4[c], w4[c], a4[c], d4[c]);
            end
            for (int n = 0; n < NCORE && pending != 4'd0; n++) begin
                w = -1;
                for (int s = 0; s < NCORE; s++) begin
                    if (w < 0 && pending[(rr_model + s) % NCORE]) w = (rr_model + s) % NCORE;
                end
                expd = model_op(r4[w], w4[w], a4[w], d4[w], e);
                rr_model = (w + 1) % NCORE;
                for (int k = 1; k <= 2; k++) begin
                    @(negedge clk);
                    check("cont_gap", 32'(ack), 32'd0);
                end
                @(negedge clk);
                check("cont_ack", 32'(ack), onehot(w));
                check("cont_data", fromdata, expd);
                check_err("cont_err", e);
                pending[w] = 1'b0;
                req[w] = 1'b0;
            end
            @(negedge clk);
            check("cont_done", 32'(ack), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
